// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the hazard stall unit: FSM state encodings and the zero register index.
package hazard_stall_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LU_STALL = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_stat_counter.sv
// Saturating up-counter with enable and synchronous clear.
module hazard_stat_counter #(
    parameter int unsigned     Width  = 8,
    parameter logic [Width-1:0] MaxVal = '1
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != MaxVal)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for load-use, taken-branch and data-memory wait hazards.
// Optional statistics counters are built when STALL_STATS_EN is defined.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16
`ifdef STALL_STATS_EN
    ,
    parameter int unsigned CNT_W    = 32
`endif
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic [4:0]       id_ex_rt_i,
    input  logic             id_ex_mem_read_i,
    input  logic             ex_branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             id_ex_write_o,
    output logic             ex_mem_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             mem_wb_bubble_o,
`ifdef STALL_STATS_EN
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o,
`endif
    output logic             mem_timeout_o
);

    localparam int unsigned      WaitW    = $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] WaitMax  = WaitW'(MAX_WAIT);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

    state_e           state_q, state_d;
    logic             timeout_q;
    logic [WaitW-1:0] wait_cnt;
    logic             freeze;
    logic             lu;

    assign freeze = mem_req_i & ~mem_ready_i;

    // A second bubble for the same load is suppressed while in S_LU_STALL.
    assign lu = id_ex_mem_read_i && (id_ex_rt_i != REG_ZERO) &&
                ((id_rs_i == id_ex_rt_i) || (id_uses_rt_i && (id_rt_i == id_ex_rt_i))) &&
                (state_q != S_LU_STALL);

    always_comb begin
        pc_write_o      = 1'b1;
        if_id_write_o   = 1'b1;
        id_ex_write_o   = 1'b1;
        ex_mem_write_o  = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_flush_o   = 1'b0;
        mem_wb_bubble_o = 1'b0;
        if (rst_i) begin
            pc_write_o      = 1'b0;
            if_id_write_o   = 1'b0;
            id_ex_write_o   = 1'b0;
            ex_mem_write_o  = 1'b0;
            if_id_flush_o   = 1'b1;
            id_ex_flush_o   = 1'b1;
            mem_wb_bubble_o = 1'b1;
        end else if (freeze) begin
            pc_write_o      = 1'b0;
            if_id_write_o   = 1'b0;
            id_ex_write_o   = 1'b0;
            ex_mem_write_o  = 1'b0;
            mem_wb_bubble_o = 1'b1;
        end else if (ex_branch_taken_i) begin
            // The ID instruction is on the wrong path, so any load-use match is moot.
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (lu) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            id_ex_flush_o = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (freeze) begin
                    state_d = S_MEM_WAIT;
                end else if (lu && !ex_branch_taken_i) begin
                    state_d = S_LU_STALL;
                end
            end
            S_LU_STALL: state_d = freeze ? S_MEM_WAIT : S_IDLE;
            S_MEM_WAIT: state_d = freeze ? S_MEM_WAIT : S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (freeze && (wait_cnt == WaitLast)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Wait counter restarts from zero on every non-frozen cycle.
    hazard_stat_counter #(
        .Width  (WaitW),
        .MaxVal (WaitMax)
    ) u_wait_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i | ~freeze),
        .en_i  (freeze),
        .cnt_o (wait_cnt)
    );

    assign mem_timeout_o = timeout_q;

`ifdef STALL_STATS_EN
    logic stall_en;
    logic flush_en;

    assign stall_en = freeze | (lu & ~ex_branch_taken_i);
    assign flush_en = ~freeze & ex_branch_taken_i;

    hazard_stat_counter #(
        .Width  (CNT_W),
        .MaxVal ({CNT_W{1'b1}})
    ) u_stall_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .en_i  (stall_en),
        .cnt_o (stall_cycles_o)
    );

    hazard_stat_counter #(
        .Width  (CNT_W),
        .MaxVal ({CNT_W{1'b1}})
    ) u_flush_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .en_i  (flush_en),
        .cnt_o (flush_count_o)
    );
`else
    // No statistics hardware in the default build.
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit; set STALL_STATS_EN to also check the statistics ports.
module tb_hazard_stall_unit;

    localparam int unsigned MW = 5;

    // Output vector: {pc, if_id, id_ex, ex_mem, if_id_flush, id_ex_flush, mem_wb_bubble, timeout}
    localparam logic [7:0] O_NORM = 8'hF0;
    localparam logic [7:0] O_LU   = 8'h34;
    localparam logic [7:0] O_BR   = 8'hFC;
    localparam logic [7:0] O_FRZ  = 8'h02;
    localparam logic [7:0] O_RST  = 8'h0E;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, id_ex_rt;
    logic       id_uses_rt, id_ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic       pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic       if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout;
`ifdef STALL_STATS_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];
    logic [7:0] mon_exp;
    string      mon_tag;

    hazard_stall_unit #(
        .MAX_WAIT (MW)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .id_rs_i           (id_rs),
        .id_rt_i           (id_rt),
        .id_uses_rt_i      (id_uses_rt),
        .id_ex_rt_i        (id_ex_rt),
        .id_ex_mem_read_i  (id_ex_mem_read),
        .ex_branch_taken_i (ex_branch_taken),
        .mem_req_i         (mem_req),
        .mem_ready_i       (mem_ready),
        .pc_write_o        (pc_write),
        .if_id_write_o     (if_id_write),
        .id_ex_write_o     (id_ex_write),
        .ex_mem_write_o    (ex_mem_write),
        .if_id_flush_o     (if_id_flush),
        .id_ex_flush_o     (id_ex_flush),
        .mem_wb_bubble_o   (mem_wb_bubble),
`ifdef STALL_STATS_EN
        .stall_cycles_o    (stall_cycles),
        .flush_count_o     (flush_count),
`endif
        .mem_timeout_o     (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus just after the edge and queue its expected outputs.
    task automatic step(input string tag, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic uses, input logic [4:0] exrt, input logic memrd,
                        input logic br, input logic req, input logic rdy, input logic [7:0] exp);
        @(posedge clk);
        #1;
        rst             = r;
        id_rs           = rs;
        id_rt           = rt;
        id_uses_rt      = uses;
        id_ex_rt        = exrt;
        id_ex_mem_read  = memrd;
        ex_branch_taken = br;
        mem_req         = req;
        mem_ready       = rdy;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            check_eq(mon_tag, {24'd0, pc_write, if_id_write, id_ex_write, ex_mem_write,
                               if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout},
                     {24'd0, mon_exp});
        end
    end

    initial begin
        rst = 1'b1;
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_ex_rt = '0;
        id_ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        //   tag            rst rs    rt    use exrt  rd   br   req  rdy  expected
        step("reset",       1, 5'd0, 5'd0, 0, 5'd0, 0,   0,   0,   0,   O_RST);
        step("idle",        0, 5'd0, 5'd0, 0, 5'd0, 0,   0,   0,   0,   O_NORM);
        step("lu_rs",       0, 5'd8, 5'd0, 0, 5'd8, 1,   0,   0,   0,   O_LU);
        step("lu_held",     0, 5'd8, 5'd0, 0, 5'd8, 1,   0,   0,   0,   O_NORM);
        step("lu_zero",     0, 5'd0, 5'd0, 0, 5'd0, 1,   0,   0,   0,   O_NORM);
        step("lu_rt_unused",0, 5'd3, 5'd8, 0, 5'd8, 1,   0,   0,   0,   O_NORM);
        step("lu_rt_used",  0, 5'd3, 5'd8, 1, 5'd8, 1,   0,   0,   0,   O_LU);
        step("idle2",       0, 5'd0, 5'd0, 0, 5'd0, 0,   0,   0,   0,   O_NORM);
        step("br_over_lu",  0, 5'd8, 5'd0, 0, 5'd8, 1,   1,   0,   0,   O_BR);
        step("lu_after_br", 0, 5'd8, 5'd0, 0, 5'd8, 1,   0,   0,   0,   O_LU);
        step("idle3",       0, 5'd0, 5'd0, 0, 5'd0, 0,   0,   0,   0,   O_NORM);
        for (int i = 0; i < 3; i++) begin
            step("mem_wait",0, 5'd0, 5'd0, 0, 5'd0, 0,   0,   1,   0,   O_FRZ);
        end
        step("mem_done",    0, 5'd0, 5'd0, 0, 5'd0, 0,   0,   1,   1,   O_NORM);
        step("frz_prio",    0, 5'd8, 5'd0, 0, 5'd8, 1,   1,   1,   0,   O_FRZ);
        step("br_after_frz",0, 5'd0, 5'd0, 0, 5'd0, 0,   1,   0,   0,   O_BR);
        step("idle4",       0, 5'd0, 5'd0, 0, 5'd0, 0,   0,   0,   0,   O_NORM);
`ifdef STALL_STATS_EN
        check_eq("stall_cycles", stall_cycles, 32'd7);
        check_eq("flush_count", flush_count, 32'd2);
`endif
        for (int i = 0; i < int'(MW) - 1; i++) begin
            step("wait_short",0, 5'd0, 5'd0, 0, 5'd0, 0, 0,   1,   0,   O_FRZ);
        end
        step("no_timeout",  0, 5'd0, 5'd0, 0, 5'd0, 0,   0,   0,   0,   O_NORM);
        for (int i = 0; i < int'(MW); i++) begin
            step("wait_long",0, 5'd0, 5'd0, 0, 5'd0, 0,  0,   1,   0,   O_FRZ);
        end
        step("timeout_set", 0, 5'd0, 5'd0, 0, 5'd0, 0,   0,   1,   0,   O_FRZ  | 8'h01);
        step("timeout_hold",0, 5'd0, 5'd0, 0, 5'd0, 0,   0,   0,   0,   O_NORM | 8'h01);
        step("lu_timeout",  0, 5'd8, 5'd0, 0, 5'd8, 1,   0,   0,   0,   O_LU   | 8'h01);
        step("idle_timeout",0, 5'd0, 5'd0, 0, 5'd0, 0,   0,   0,   0,   O_NORM | 8'h01);
        step("rst_frz",     1, 5'd0, 5'd0, 0, 5'd0, 0,   0,   1,   0,   O_RST  | 8'h01);
        step("after_rst",   0, 5'd0, 5'd0, 0, 5'd0, 0,   0,   0,   0,   O_NORM);
`ifdef STALL_STATS_EN
        @(posedge clk);
        #1;
        check_eq("stall_cleared", stall_cycles, 32'd0);
        check_eq("flush_cleared", flush_count, 32'd0);
`endif
        repeat (2) @(negedge clk);
        check_eq("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
